mode_sequencer: RTL and testbench

//  Top-level mode controller for the digital clock; sits between button_detect pulses and the time units.

---
 rtl/clk_ctrl_pkg.sv | 47 ++++
 rtl/mode_sequencer_if.sv | 33 +++
 rtl/mode_sequencer_sec_timeout.sv | 26 ++
 rtl/mode_sequencer.sv | 130 +++++++++++++
 tb/tb_mode_sequencer.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared mode encodings, button codes and BCD field layout
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    M_CLOCK  = 3'd0,
    M_SET    = 3'd1,
    M_ALARM  = 3'd2,
    M_COUNT  = 3'd3,
    M_SELECT = 3'd4
  } mode_t;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_MID   = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_UP    = 4;

  localparam logic [4:0] B_RIGHT = 5'b00001 << BTN_RIGHT;
  localparam logic [4:0] B_DOWN  = 5'b00001 << BTN_DOWN;
  localparam logic [4:0] B_MID   = 5'b00001 << BTN_MID;
  localparam logic [4:0] B_LEFT  = 5'b00001 << BTN_LEFT;
  localparam logic [4:0] B_UP    = 5'b00001 << BTN_UP;

  // BCD time word: {hh_h[1:0],hh_l[3:0],mm_h[2:0],mm_l[3:0],ss_h[2:0],ss_l[3:0]}
  localparam int SS_L_LSB = 0;
  localparam int SS_H_LSB = 4;
  localparam int MM_L_LSB = 7;
  localparam int MM_H_LSB = 11;
  localparam int HH_L_LSB = 14;
  localparam int HH_H_LSB = 18;

  // A button counts only when exactly one bit is set
  function automatic logic btn_valid(input logic [4:0] b);
    return (b != 5'd0) && ((b & (b - 5'd1)) == 5'd0);
  endfunction

  // Time word shown for a given mode; SET edits the clock so it shows clock time
  function automatic logic [19:0] time_of(input mode_t m, input logic [19:0] clk_t,
                                          input logic [19:0] alm_t, input logic [19:0] cnt_t);
    case (m)
      M_ALARM: return alm_t;
      M_COUNT: return cnt_t;
      default: return clk_t;
    endcase
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// rtl/mode_sequencer_if.sv - button/tick inputs and unit control outputs of the mode sequencer
interface mode_sequencer_if;
  logic [4:0]  btn_pulse;
  logic        tick_1hz;
  logic        alarm_hit;
  logic [19:0] clock_time;
  logic [19:0] alarm_time;
  logic [19:0] count_time;
  logic [2:0]  mode;
  logic [19:0] disp_time;
  logic [5:0]  blink_mask;
  logic [2:0]  edit_digit;
  logic        edit_inc;
  logic        edit_dec;
  logic        edit_tgt;
  logic        load_clock;
  logic        load_alarm;
  logic        count_run;
  logic        count_clear;
  logic        alarm_ring;

  modport master (
    output btn_pulse, tick_1hz, alarm_hit, clock_time, alarm_time, count_time,
    input  mode, disp_time, blink_mask, edit_digit, edit_inc, edit_dec, edit_tgt,
           load_clock, load_alarm, count_run, count_clear, alarm_ring
  );

  modport slave (
    input  btn_pulse, tick_1hz, alarm_hit, clock_time, alarm_time, count_time,
    output mode, disp_time, blink_mask, edit_digit, edit_inc, edit_dec, edit_tgt,
           load_clock, load_alarm, count_run, count_clear, alarm_ring
  );
endinterface

// File: rtl/mode_sequencer_sec_timeout.sv
// rtl/mode_sequencer_sec_timeout.sv - loadable seconds down-counter that flags the tick reaching zero
module sec_timeout #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);
  logic [W-1:0] count;

  // Load wins over a same-cycle tick so a reload always restarts the full period
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - 1'b1;
  end

  // High in the cycle whose tick takes the count from 1 to 0
  assign expire = tick && (count == W'(1));
endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - clock/set/alarm/count/select mode FSM with display mux, blink and alarm ring
module mode_sequencer
  import clk_ctrl_pkg::*;
#(
  parameter int MENU_TIMEOUT = 10,
  parameter int RING_SECS    = 30
) (
  input logic        clk_sys,
  input logic        rst,
  mode_sequencer_if.slave bus
);
  mode_t       mode_r, mode_nx, sel_r, sel_nx, shown;
  logic [2:0]  digit_r, digit_nx;
  logic        phase_r, phase_nx;
  logic        run_r, run_nx, ring_r, ring_nx;
  logic        inc_r, inc_nx, dec_r, dec_nx, ldc_r, ldc_nx, lda_r, lda_nx, clr_r, clr_nx;
  logic        tgt_r, tgt_nx;
  logic [19:0] disp_r, disp_nx;
  logic [5:0]  mask_r, mask_nx;
  logic        act, menu_load, menu_expire, ring_load, ring_expire;
  logic [5:0]  ring_val;

  sec_timeout #(.W(6)) u_menu (
    .clk(clk_sys), .rst(rst), .load(menu_load), .load_val(6'(MENU_TIMEOUT)),
    .tick(bus.tick_1hz), .expire(menu_expire)
  );

  sec_timeout #(.W(6)) u_ring (
    .clk(clk_sys), .rst(rst), .load(ring_load), .load_val(ring_val),
    .tick(bus.tick_1hz), .expire(ring_expire)
  );

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mode_r <= M_CLOCK;  sel_r <= M_CLOCK;  digit_r <= 3'd0;  phase_r <= 1'b0;
      run_r  <= 1'b0;     ring_r <= 1'b0;    inc_r <= 1'b0;    dec_r <= 1'b0;
      ldc_r  <= 1'b0;     lda_r <= 1'b0;     clr_r <= 1'b0;    tgt_r <= 1'b0;
      disp_r <= 20'd0;    mask_r <= 6'd0;
    end else begin
      mode_r <= mode_nx;  sel_r <= sel_nx;   digit_r <= digit_nx;  phase_r <= phase_nx;
      run_r  <= run_nx;   ring_r <= ring_nx; inc_r <= inc_nx;      dec_r <= dec_nx;
      ldc_r  <= ldc_nx;   lda_r <= lda_nx;   clr_r <= clr_nx;      tgt_r <= tgt_nx;
      disp_r <= disp_nx;  mask_r <= mask_nx;
    end
  end

  // Next-state, strobe, ring and display decode
  always_comb begin
    mode_nx = mode_r;  sel_nx = sel_r;  digit_nx = digit_r;  run_nx = run_r;  ring_nx = ring_r;
    inc_nx = 1'b0;  dec_nx = 1'b0;  ldc_nx = 1'b0;  lda_nx = 1'b0;  clr_nx = 1'b0;
    menu_load = 1'b0;  ring_load = 1'b0;  ring_val = 6'd0;
    phase_nx = phase_r ^ bus.tick_1hz;
    // A ringing buzzer swallows every button, including multi-bit ones
    act = btn_valid(bus.btn_pulse) && !ring_r;

    if (ring_r && bus.btn_pulse != 5'd0) begin
      ring_nx = 1'b0;  ring_load = 1'b1;
    end else if (ring_r && ring_expire) begin
      ring_nx = 1'b0;
    end else if (!ring_r && bus.alarm_hit && mode_r != M_SET && mode_r != M_ALARM) begin
      ring_nx = 1'b1;  ring_load = 1'b1;  ring_val = 6'(RING_SECS);
    end

    case (mode_r)
      M_CLOCK: if (act && bus.btn_pulse == B_MID) begin
        mode_nx = M_SELECT;  sel_nx = M_CLOCK;
      end
      M_COUNT: if (act) begin
        case (bus.btn_pulse)
          B_MID:   begin mode_nx = M_SELECT; sel_nx = M_COUNT; end
          B_UP:    run_nx = !run_r;
          B_DOWN:  clr_nx = 1'b1;
          default: ;
        endcase
      end
      M_SET, M_ALARM: if (act) begin
        case (bus.btn_pulse)
          B_LEFT:  digit_nx = (digit_r == 3'd5) ? 3'd0 : digit_r + 3'd1;
          B_RIGHT: digit_nx = (digit_r == 3'd0) ? 3'd5 : digit_r - 3'd1;
          B_UP:    inc_nx = 1'b1;
          B_DOWN:  dec_nx = 1'b1;
          B_MID: begin
            ldc_nx  = (mode_r == M_SET);
            lda_nx  = (mode_r == M_ALARM);
            mode_nx = M_CLOCK;
          end
          default: ;
        endcase
      end
      M_SELECT: if (act) begin
        menu_load = 1'b1;
        case (bus.btn_pulse)
          B_RIGHT: sel_nx = (sel_r == M_COUNT) ? M_CLOCK : mode_t'(sel_r + 3'd1);
          B_LEFT:  sel_nx = (sel_r == M_CLOCK) ? M_COUNT : mode_t'(sel_r - 3'd1);
          B_MID:   mode_nx = sel_r;
          default: ;
        endcase
      end else if (menu_expire) begin
        mode_nx = M_CLOCK;
      end
      default: mode_nx = M_CLOCK;
    endcase

    if (mode_nx == M_SELECT && mode_r != M_SELECT) menu_load = 1'b1;
    if ((mode_nx == M_SET || mode_nx == M_ALARM) && mode_nx != mode_r) digit_nx = 3'd0;

    tgt_nx  = (mode_nx == M_ALARM);
    shown   = (mode_nx == M_SELECT) ? sel_nx : mode_nx;
    disp_nx = time_of(shown, bus.clock_time, bus.alarm_time, bus.count_time);
    case (mode_nx)
      M_SET, M_ALARM: mask_nx = phase_nx ? (6'b1 << digit_nx) : 6'd0;
      M_SELECT:       mask_nx = phase_nx ? 6'h3F : 6'd0;
      default:        mask_nx = 6'd0;
    endcase
  end

  assign bus.mode        = mode_r;
  assign bus.disp_time   = disp_r;
  assign bus.blink_mask  = mask_r;
  assign bus.edit_digit  = digit_r;
  assign bus.edit_inc    = inc_r;
  assign bus.edit_dec    = dec_r;
  assign bus.edit_tgt    = tgt_r;
  assign bus.load_clock  = ldc_r;
  assign bus.load_alarm  = lda_r;
  assign bus.count_run   = run_r;
  assign bus.count_clear = clr_r;
  assign bus.alarm_ring  = ring_r;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed self-checking bench for mode_sequencer
module tb_mode_sequencer;
  localparam logic [4:0] RIGHT = 5'b00001, DOWN = 5'b00010, MID = 5'b00100,
                         LEFT = 5'b01000, UP = 5'b10000;
  localparam logic [19:0] CT = 20'h11111, AT = 20'h22222, KT = 20'h33333;

  logic clk_sys = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk_sys = ~clk_sys;

  mode_sequencer_if bus ();

  mode_sequencer dut (.clk_sys(clk_sys), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] b, input logic t, input logic h);
    @(negedge clk_sys);
    bus.btn_pulse = b;  bus.tick_1hz = t;  bus.alarm_hit = h;
    @(negedge clk_sys);
    bus.btn_pulse = 5'd0;  bus.tick_1hz = 1'b0;  bus.alarm_hit = 1'b0;
  endtask

  task automatic press(input logic [4:0] b);
    drive(b, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_pulse = 5'd0;  bus.tick_1hz = 1'b0;  bus.alarm_hit = 1'b0;
    bus.clock_time = CT;  bus.alarm_time = AT;  bus.count_time = KT;
    repeat (3) @(negedge clk_sys);
    chk("rst_mode", bus.mode, 0);
    chk("rst_digit", bus.edit_digit, 0);
    chk("rst_ring", bus.alarm_ring, 0);
    chk("rst_run", bus.count_run, 0);
    chk("rst_mask", bus.blink_mask, 0);
    chk("rst_strobes", {bus.edit_inc, bus.edit_dec, bus.load_clock, bus.load_alarm, bus.count_clear}, 0);
    rst = 1'b0;

    // Menu navigation with preview
    press(MID);    chk("sel_mode", bus.mode, 4);  chk("sel_prev0", bus.disp_time, CT);
    press(RIGHT);  chk("sel_prev1", bus.disp_time, CT);
    press(RIGHT);  chk("sel_prev2", bus.disp_time, AT);
    press(RIGHT);  chk("sel_prev3", bus.disp_time, KT);
    press(RIGHT);  chk("sel_wrap_r", bus.disp_time, CT);
    press(LEFT);   chk("sel_wrap_l", bus.disp_time, KT);
    press(MID);    chk("count_mode", bus.mode, 3);  chk("count_disp", bus.disp_time, KT);

    // Stopwatch control
    press(UP);     chk("run_on", bus.count_run, 1);
    press(DOWN);   chk("clr_pulse", bus.count_clear, 1);  chk("clr_run", bus.count_run, 1);
    press(5'd0);   chk("clr_end", bus.count_clear, 0);
    press(MID);    chk("count_sel", bus.disp_time, KT);  chk("count_sel_mode", bus.mode, 4);
    press(LEFT);  press(LEFT);  press(LEFT);
    press(MID);    chk("back_clock", bus.mode, 0);  chk("run_persist", bus.count_run, 1);

    // Clock edit
    press(MID);  press(RIGHT);  press(MID);
    chk("set_mode", bus.mode, 1);  chk("set_digit0", bus.edit_digit, 0);  chk("set_tgt", bus.edit_tgt, 0);
    for (int i = 0; i < 6; i++) begin
      press(LEFT);
      chk("set_left", bus.edit_digit, (i + 1) % 6);
    end
    press(UP);     chk("inc_pulse", bus.edit_inc, 1);  chk("inc_tgt", bus.edit_tgt, 0);
    press(5'd0);   chk("inc_end", bus.edit_inc, 0);
    press(RIGHT);  chk("right_wrap", bus.edit_digit, 5);
    press(5'b10001);
    chk("multi_mode", bus.mode, 1);  chk("multi_digit", bus.edit_digit, 5);
    chk("multi_strobe", {bus.edit_inc, bus.edit_dec}, 0);
    ticks(1);      chk("set_blink", bus.blink_mask, 6'h20);
    press(MID);    chk("load_clock", bus.load_clock, 1);  chk("load_mode", bus.mode, 0);
    chk("clock_mask", bus.blink_mask, 0);
    press(5'd0);   chk("load_end", bus.load_clock, 0);

    // Menu timeout
    press(MID);    chk("sel_blink", bus.blink_mask, 6'h3F);
    ticks(9);      chk("to_9", bus.mode, 4);
    ticks(1);      chk("to_10", bus.mode, 0);
    press(MID);  ticks(9);  press(LEFT);  ticks(9);
    chk("to_reload", bus.mode, 4);
    drive(RIGHT, 1'b1, 1'b0);  ticks(9);
    chk("to_btn_wins", bus.mode, 4);
    ticks(1);      chk("to_expire", bus.mode, 0);

    // Alarm ring runs its full length
    drive(5'd0, 1'b0, 1'b1);  chk("ring_on", bus.alarm_ring, 1);
    ticks(29);     chk("ring_29", bus.alarm_ring, 1);
    ticks(1);      chk("ring_30", bus.alarm_ring, 0);

    // Ring silenced in COUNT; the silencing UP must not toggle the stopwatch
    press(MID);  press(LEFT);  press(MID);
    chk("count_again", bus.mode, 3);
    drive(5'd0, 1'b0, 1'b1);  chk("ring2_on", bus.alarm_ring, 1);
    ticks(5);
    press(UP);     chk("silence", bus.alarm_ring, 0);  chk("silence_run", bus.count_run, 1);
    chk("silence_mode", bus.mode, 3);
    press(DOWN);   chk("after_silence_clr", bus.count_clear, 1);

    // Alarm edit: no ring while editing
    press(MID);  press(LEFT);  press(MID);
    chk("alarm_mode", bus.mode, 2);  chk("alarm_tgt", bus.edit_tgt, 1);  chk("alarm_disp", bus.disp_time, AT);
    drive(5'd0, 1'b0, 1'b1);  chk("alarm_no_ring", bus.alarm_ring, 0);
    press(DOWN);   chk("dec_pulse", bus.edit_dec, 1);
    press(MID);    chk("load_alarm", bus.load_alarm, 1);  chk("la_no_lc", bus.load_clock, 0);
    chk("la_mode", bus.mode, 0);

    // Hit and button together: button acts and ring starts
    drive(MID, 1'b0, 1'b1);
    chk("hitbtn_mode", bus.mode, 4);  chk("hitbtn_ring", bus.alarm_ring, 1);
    press(UP);     chk("hitbtn_sil", bus.alarm_ring, 0);  chk("hitbtn_sel", bus.disp_time, CT);
    press(LEFT);   chk("hitbtn_left", bus.disp_time, KT);

    // Reset in the middle of a clock edit
    press(LEFT);  press(LEFT);  press(MID);
    press(LEFT);  press(LEFT);
    chk("pre_rst_digit", bus.edit_digit, 2);  chk("pre_rst_mode", bus.mode, 1);
    @(negedge clk_sys);  rst = 1'b1;
    @(negedge clk_sys);
    chk("midrst_mode", bus.mode, 0);  chk("midrst_digit", bus.edit_digit, 0);
    chk("midrst_load", bus.load_clock, 0);  chk("midrst_run", bus.count_run, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
